// File: rtl/call_ret_seq.sv
// CALL/RET context sequencer: streams NREGS register-file words to/from a stack RAM,
// owning state_mode, sc and sp, and stalling fetch while a sequence runs.
module call_ret_seq #(
  parameter int NREGS       = 64,
  parameter int DATA_W      = 32,
  parameter int STACK_DEPTH = 256,
  parameter int SA_W        = $clog2(STACK_DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               state_mode_next,
  output logic [1:0]               state_mode,
  output logic [7:0]               sc,
  output logic                     stall,
  output logic [$clog2(NREGS)-1:0] rf_raddr,
  input  logic [DATA_W-1:0]        rf_rdata,
  output logic [$clog2(NREGS)-1:0] rf_waddr,
  output logic [DATA_W-1:0]        rf_wdata,
  output logic                     rf_we,
  output logic [SA_W-1:0]          stk_addr,
  output logic [DATA_W-1:0]        stk_wdata,
  output logic                     stk_we,
  input  logic [DATA_W-1:0]        stk_rdata,
  output logic [SA_W:0]            sp,
  output logic                     done,
  output logic                     stk_err
);
  localparam int RA_W = $clog2(NREGS);
  localparam logic [7:0]      SC_END  = 8'(NREGS);
  localparam logic [SA_W:0]   NR_S    = (SA_W+1)'(NREGS);
  localparam logic [SA_W+1:0] NR_X    = (SA_W+2)'(NREGS);
  localparam logic [SA_W+1:0] DEPTH_X = (SA_W+2)'(STACK_DEPTH);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SAVE = 2'd1, S_REST = 2'd2} state_t;

  state_t         r_state, w_state_nxt;
  logic [7:0]     r_sc, w_sc_nxt;
  logic [SA_W:0]  r_sp, w_sp_nxt;
  logic [SA_W+1:0] w_sp_x;
  logic           w_call_ok, w_ret_ok, w_last;

  assign w_sp_x    = {1'b0, r_sp};
  assign w_call_ok = (w_sp_x + NR_X) <= DEPTH_X;
  assign w_ret_ok  = w_sp_x >= NR_X;
  assign w_last    = (r_sc == SC_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sc    <= '0;
      r_sp    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sc    <= w_sc_nxt;
      r_sp    <= w_sp_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sc_nxt    = r_sc;
    w_sp_nxt    = r_sp;
    rf_raddr    = '0;
    rf_waddr    = '0;
    rf_wdata    = '0;
    rf_we       = 1'b0;
    stk_addr    = '0;
    stk_wdata   = '0;
    stk_we      = 1'b0;
    done        = 1'b0;
    stk_err     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_sc_nxt = '0;
        if (state_mode_next == 2'd1) begin
          if (w_call_ok) w_state_nxt = S_SAVE;
          else           stk_err     = rst_n;
        end else if (state_mode_next == 2'd2) begin
          if (w_ret_ok) w_state_nxt = S_REST;
          else          stk_err     = rst_n;
        end
      end
      S_SAVE: begin
        if (w_last) begin
          done        = 1'b1;
          w_sp_nxt    = r_sp + NR_S;
          w_sc_nxt    = '0;
          w_state_nxt = S_IDLE;
        end else begin
          rf_raddr  = RA_W'(r_sc);
          stk_addr  = SA_W'(r_sp + (SA_W+1)'(r_sc));
          stk_wdata = rf_rdata;
          stk_we    = 1'b1;
          w_sc_nxt  = r_sc + 8'd1;
        end
      end
      S_REST: begin
        // Reads lead writes by one cycle to cover the RAM read latency.
        if (!w_last) stk_addr = SA_W'(r_sp - NR_S + (SA_W+1)'(r_sc));
        if (r_sc != 8'd0) begin
          rf_waddr = RA_W'(r_sc - 8'd1);
          rf_wdata = stk_rdata;
          rf_we    = 1'b1;
        end
        if (w_last) begin
          done        = 1'b1;
          w_sp_nxt    = r_sp - NR_S;
          w_sc_nxt    = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_sc_nxt = r_sc + 8'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign state_mode = r_state;
  assign sc         = r_sc;
  assign sp         = r_sp;
  assign stall      = (r_state != S_IDLE);
endmodule
